// File: rtl/mem_ring_fifo.sv
// Ring-buffer FIFO driving an external RAM port; writes land 1 cycle after push, popped words arrive RD_LATENCY+1 cycles after pop.
// Backpressure: push is dropped while full; pop is only taken when pop_ready (IDLE and non-empty), one read in flight at a time.
module mem_ring_fifo #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  input  logic              pop,
  output logic              pop_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [ADDR_W:0]   used,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_wr_enable,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              mem_rd_enable,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [2:0]      LAT_LOAD = 3'(RD_LATENCY);

  logic [0:0]        state;
  logic [2:0]        lat_cnt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_acc;
  logic              pop_acc;

  assign full      = (used == DEPTH);
  assign pop_ready = (state == ST_IDLE) && (used != '0);
  assign push_acc  = push && !full;
  assign pop_acc   = pop && pop_ready;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state         <= ST_IDLE;
      lat_cnt       <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      used          <= '0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      mem_wr_addr   <= '0;
      mem_wr_data   <= '0;
      mem_wr_enable <= 1'b0;
      mem_rd_addr   <= '0;
      mem_rd_enable <= 1'b0;
    end else begin
      mem_wr_enable <= 1'b0;
      mem_rd_enable <= 1'b0;
      out_valid     <= 1'b0;
      if (clear) begin
        // Flush also drops any read in flight, so its out_valid never fires.
        state   <= ST_IDLE;
        lat_cnt <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        used    <= '0;
      end else begin
        if (push_acc) begin
          mem_wr_enable <= 1'b1;
          mem_wr_addr   <= wr_ptr;
          mem_wr_data   <= push_data;
          wr_ptr        <= wr_ptr + 1'b1;
        end
        if (pop_acc) begin
          mem_rd_enable <= 1'b1;
          mem_rd_addr   <= rd_ptr;
          rd_ptr        <= rd_ptr + 1'b1;
          lat_cnt       <= LAT_LOAD;
          state         <= ST_WAIT;
        end
        if (push_acc && !pop_acc) begin
          used <= used + 1'b1;
        end else if (pop_acc && !push_acc) begin
          used <= used - 1'b1;
        end
        // Counter spans the cycle the RAM samples the strobe plus RD_LATENCY.
        if (state == ST_WAIT) begin
          if (lat_cnt == '0) begin
            out_data  <= mem_rd_data;
            out_valid <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_ring_fifo.sv
// Directed bench for mem_ring_fifo with a behavioural RAM of fixed read latency.
module tb_mem_ring_fifo;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int LAT    = 2;

  logic              clk = 1'b0;
  logic              nRst;
  logic              clear;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              full;
  logic              pop;
  logic              pop_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic [ADDR_W:0]   used;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_enable;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_enable;
  logic [DATA_W-1:0] mem_rd_data;

  int errors = 0;
  int checks = 0;

  mem_ring_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(LAT)) dut (
    .clk(clk), .nRst(nRst), .clear(clear), .push(push), .push_data(push_data),
    .full(full), .pop(pop), .pop_ready(pop_ready), .out_data(out_data),
    .out_valid(out_valid), .used(used), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_enable(mem_wr_enable),
    .mem_rd_addr(mem_rd_addr), .mem_rd_enable(mem_rd_enable),
    .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // RAM: writes on the edge that sees wr_enable; read data valid LAT edges after the sampling edge.
  logic [DATA_W-1:0] ram [256];
  logic [DATA_W-1:0] pipe [LAT];
  always @(posedge clk) begin
    if (mem_wr_enable) ram[mem_wr_addr] <= mem_wr_data;
    pipe[0] <= mem_rd_enable ? ram[mem_rd_addr] : 16'hDEAD;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign mem_rd_data = pipe[LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    nRst = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0;
    tick(); tick();
    checks++; if (used !== 9'd0) begin errors++; $display("FAIL reset_used: got %0d want 0", used); end
    checks++; if ({full, pop_ready, out_valid, mem_wr_enable, mem_rd_enable} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b want 00000", {full, pop_ready, out_valid, mem_wr_enable, mem_rd_enable}); end
    checks++; if ({out_data, mem_wr_data, mem_wr_addr, mem_rd_addr} !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", {out_data, mem_wr_data, mem_wr_addr, mem_rd_addr}); end
    nRst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit seen;
    push = 1'b1; push_data = 16'hABCD;
    tick();
    push = 1'b0;
    checks++; if (mem_wr_enable !== 1'b1) begin errors++; $display("FAIL single_wr_en: got %b want 1", mem_wr_enable); end
    checks++; if (mem_wr_addr !== 8'h00) begin errors++; $display("FAIL single_wr_addr: got %h want 00", mem_wr_addr); end
    checks++; if (mem_wr_data !== 16'hABCD) begin errors++; $display("FAIL single_wr_data: got %h want abcd", mem_wr_data); end
    checks++; if (used !== 9'd1 || pop_ready !== 1'b1) begin errors++; $display("FAIL single_used: got used=%0d rdy=%b want 1/1", used, pop_ready); end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    checks++; if (mem_rd_enable !== 1'b1 || mem_rd_addr !== 8'h00) begin errors++; $display("FAIL single_rd: got en=%b addr=%h want 1/00", mem_rd_enable, mem_rd_addr); end
    checks++; if (used !== 9'd0 || pop_ready !== 1'b0) begin errors++; $display("FAIL single_after_pop: got used=%0d rdy=%b want 0/0", used, pop_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || mem_wr_enable !== 1'b0) begin errors++; $display("FAIL single_early1: got vld=%b wr=%b want 0/0", out_valid, mem_wr_enable); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early2: got %b want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 16'hABCD) begin errors++; $display("FAIL single_out: got vld=%b data=%h want 1/abcd", out_valid, out_data); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_strobe: got %b want 0", out_valid); end
  endtask

  task automatic test_full_wrap();
    bit seen;
    do_clear();
    for (int i = 0; i < 256; i++) begin
      push = 1'b1; push_data = 16'(i);
      tick();
    end
    push = 1'b0;
    checks++; if (full !== 1'b1 || used !== 9'd256) begin errors++; $display("FAIL full_flag: got full=%b used=%0d want 1/256", full, used); end
    push = 1'b1; push_data = 16'h01FF;
    tick();
    push = 1'b0;
    checks++; if (mem_wr_enable !== 1'b0 || used !== 9'd256) begin errors++; $display("FAIL full_drop: got wr=%b used=%0d want 0/256", mem_wr_enable, used); end
    for (int i = 0; i < 256; i++) begin
      pop = 1'b1;
      tick();
      pop = 1'b0;
      checks++; if (mem_rd_enable !== 1'b1 || mem_rd_addr !== 8'(i)) begin errors++; $display("FAIL drain_addr[%0d]: got en=%b addr=%h want 1/%h", i, mem_rd_enable, mem_rd_addr, 8'(i)); end
      wait_valid(8, seen);
      checks++; if (!seen || out_data !== 16'(i)) begin errors++; $display("FAIL drain_data[%0d]: got seen=%b data=%h want 1/%h", i, seen, out_data, 16'(i)); end
    end
    checks++; if (used !== 9'd0 || full !== 1'b0) begin errors++; $display("FAIL drain_empty: got used=%0d full=%b want 0/0", used, full); end
    push = 1'b1; push_data = 16'hBEEF;
    tick();
    push = 1'b0;
    checks++; if (mem_wr_addr !== 8'h00) begin errors++; $display("FAIL wrap_wr_addr: got %h want 00", mem_wr_addr); end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    checks++; if (mem_rd_addr !== 8'h00) begin errors++; $display("FAIL wrap_rd_addr: got %h want 00", mem_rd_addr); end
    wait_valid(8, seen);
    checks++; if (!seen || out_data !== 16'hBEEF) begin errors++; $display("FAIL wrap_data: got seen=%b data=%h want 1/beef", seen, out_data); end
  endtask

  task automatic test_push_pop_same();
    bit seen;
    do_clear();
    for (int i = 0; i < 5; i++) begin
      push = 1'b1; push_data = 16'(100 + i);
      tick();
    end
    push = 1'b0;
    checks++; if (used !== 9'd5) begin errors++; $display("FAIL pp_pre_used: got %0d want 5", used); end
    push = 1'b1; pop = 1'b1; push_data = 16'h0777;
    tick();
    push = 1'b0; pop = 1'b0;
    checks++; if (used !== 9'd5) begin errors++; $display("FAIL pp_used: got %0d want 5", used); end
    checks++; if (mem_wr_enable !== 1'b1 || mem_rd_enable !== 1'b1) begin errors++; $display("FAIL pp_strobes: got wr=%b rd=%b want 1/1", mem_wr_enable, mem_rd_enable); end
    checks++; if (mem_wr_addr !== 8'h05 || mem_rd_addr !== 8'h00) begin errors++; $display("FAIL pp_addrs: got wr=%h rd=%h want 05/00", mem_wr_addr, mem_rd_addr); end
    wait_valid(8, seen);
    checks++; if (!seen || out_data !== 16'd100) begin errors++; $display("FAIL pp_data: got seen=%b data=%h want 1/0064", seen, out_data); end
  endtask

  task automatic test_clear_wait();
    bit seen;
    do_clear();
    push = 1'b1; push_data = 16'h1234;
    tick();
    push = 1'b0;
    pop = 1'b1;
    tick();
    pop = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (used !== 9'd0 || pop_ready !== 1'b0 || mem_rd_enable !== 1'b0) begin errors++; $display("FAIL clr_state: got used=%0d rdy=%b rd=%b want 0/0/0", used, pop_ready, mem_rd_enable); end
    wait_valid(6, seen);
    checks++; if (seen) begin errors++; $display("FAIL clr_no_valid: got out_valid seen=%b want 0", seen); end
    push = 1'b1; push_data = 16'h5555;
    tick();
    push = 1'b0;
    checks++; if (mem_wr_enable !== 1'b1 || mem_wr_addr !== 8'h00) begin errors++; $display("FAIL clr_wr_addr: got en=%b addr=%h want 1/00", mem_wr_enable, mem_wr_addr); end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    checks++; if (mem_rd_addr !== 8'h00) begin errors++; $display("FAIL clr_rd_addr: got %h want 00", mem_rd_addr); end
    wait_valid(8, seen);
    checks++; if (!seen || out_data !== 16'h5555) begin errors++; $display("FAIL clr_data: got seen=%b data=%h want 1/5555", seen, out_data); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    push = 1'b1; push_data = 16'h2222;
    tick();
    push = 1'b0;
    pop = 1'b1;
    tick();
    pop = 1'b0;
    nRst = 1'b0;
    #1;
    checks++; if ({mem_rd_enable, pop_ready, out_valid, full} !== 4'b0 || used !== 9'd0) begin errors++; $display("FAIL rst_async_flags: got %b used=%0d want 0000/0", {mem_rd_enable, pop_ready, out_valid, full}, used); end
    checks++; if ({out_data, mem_rd_addr, mem_wr_addr, mem_wr_data} !== '0) begin errors++; $display("FAIL rst_async_data: got %h want 0", {out_data, mem_rd_addr, mem_wr_addr, mem_wr_data}); end
    tick(); tick();
    nRst = 1'b1;
    wait_valid(6, seen);
    checks++; if (seen) begin errors++; $display("FAIL rst_no_valid: got out_valid seen=%b want 0", seen); end
    push = 1'b1; push_data = 16'h3333;
    tick();
    push = 1'b0;
    checks++; if (mem_wr_addr !== 8'h00 || used !== 9'd1) begin errors++; $display("FAIL rst_push: got addr=%h used=%0d want 00/1", mem_wr_addr, used); end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    wait_valid(8, seen);
    checks++; if (!seen || out_data !== 16'h3333) begin errors++; $display("FAIL rst_pop_data: got seen=%b data=%h want 1/3333", seen, out_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_wrap();
    test_push_pop_same();
    test_clear_wait();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_ring_fifo.md
Name: mem_ring_fifo

Overview:
- FIFO controller that acts as the client (initiator) of the IMemory-style RAM port, the opposite end from the Altera memory wrapper.
- Converts a push/pop word stream into wr_addr/wr_data/wr_enable and rd_addr/rd_enable transactions, and collects rd_data after the fixed memory read latency.
- Used as the word buffer between the SPI and MIL-STD-1553 sides.

Parameters:
- ADDR_W, 8, memory address width; FIFO depth = 2**ADDR_W words (256).
- DATA_W, 16, word width.
- RD_LATENCY, 2, clk cycles from the edge sampling mem_rd_enable=1 to the edge where mem_rd_data is valid (1..4).

Ports:
- clk  in  1  system clock, rising edge.
- nRst  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous flush; empties the FIFO.
- push  in  1  write request.
- push_data  in  DATA_W  word to store.
- full  out  1  no free slot; push ignored while 1.
- pop  in  1  read request.
- pop_ready  out  1  pop will be accepted this cycle.
- out_data  out  DATA_W  popped word.
- out_valid  out  1  one-cycle strobe: out_data valid.
- used  out  ADDR_W+1  words stored (0..256).
- mem_wr_addr  out  ADDR_W  to memory.
- mem_wr_data  out  DATA_W  to memory.
- mem_wr_enable  out  1  to memory.
- mem_rd_addr  out  ADDR_W  to memory.
- mem_rd_enable  out  1  to memory.
- mem_rd_data  in  DATA_W  from memory.

Behaviour:
- Reset (nRst=0, async): wr_ptr=rd_ptr=0, used=0, state=IDLE; all outputs 0 (full=0, pop_ready=0, out_valid=0, out_data=0, mem_* = 0).
- All outputs are registered except full and pop_ready, which are decoded from registered state.
- Push accept: push=1 && full=0 at edge N.
  - Edge N registers mem_wr_enable=1, mem_wr_addr=wr_ptr, mem_wr_data=push_data.
  - mem_wr_enable is held for exactly one cycle; wr_ptr++ and used++ at edge N.
  - push while full: no write, no state change.
- full = (used == 2**ADDR_W).
- Read FSM:
  - IDLE: pop_ready = (used != 0).
    - pop=1 && pop_ready at edge N: register mem_rd_enable=1 (one cycle), mem_rd_addr=rd_ptr; rd_ptr++, used--; load latency counter; go to WAIT.
  - WAIT: pop_ready=0; pop is ignored.
    - Capture mem_rd_data into out_data, assert out_valid for one cycle at edge N+1+RD_LATENCY, then return to IDLE.
    - Next pop is accepted on the cycle that out_valid is high at the earliest.
- Read-after-write: used counts a word only from the cycle mem_wr_enable is driven, so the RAM sees the write one cycle before any read of that address.
- Push and pop accepted in the same cycle: used unchanged; both memory strobes fire in the same cycle at different addresses (FIFO non-empty guarantees this).
- Pointers wrap modulo 2**ADDR_W; used never wraps.
- clear=1 at an edge:
  - pointers=0, used=0, state=IDLE, latency counter cleared.
  - Any in-flight read is aborted: its out_valid is suppressed.
  - mem strobes are 0 next cycle.
  - clear has priority over push/pop in the same cycle.
- Reset mid-read: identical to clear; out_valid never fires for the aborted read.

Test Plan:
- Reset, push 16'hABCD -> next cycle mem_wr_enable=1, mem_wr_addr=8'h00, mem_wr_data=16'hABCD; used=1; pop_ready=1.
- pop after single push (RD_LATENCY=2, memory returns 16'hABCD) -> mem_rd_enable=1 with mem_rd_addr=0 one cycle after pop; out_valid=1 with out_data=16'hABCD 3 cycles after the pop edge; used=0; pop_ready=0.
- Push 256 words 16'h0000..16'h00FF -> full=1 after the 256th; a 257th push produces no mem_wr_enable; pop all 256 -> values returned in order 0..255 with rd_addr wrapping 8'hFF->8'h00.
- Push and pop accepted in the same cycle with used=5 -> used stays 5; mem_wr_enable and mem_rd_enable both high next cycle at different addresses.
- Pop accepted, then clear asserted during WAIT -> no out_valid for the aborted read; used=0; pointers=0; next push writes to addr 0.
- nRst pulsed low mid-WAIT -> all outputs 0 immediately (async); no out_valid afterward; normal push/pop works after release.
